skewed_operand_buffer: RTL and testbench

- Parametrised LINES x DEPTH operand store for the Mini-TPU systolic array; successor to the fixed 4x4 memory.
- Host writes one element per cycle. On `start`, a sequencer streams every line out autonomously, one element per cycle.
- In skew mode, line i is delayed i cycles, so operands enter the array diagonally. Otherwise all lines stream aligned.
- Registered outputs with per-line valid, plus busy/done handshake.

---
 rtl/skewed_operand_buffer_if.sv | 33 +++
 rtl/skewed_operand_buffer.sv | 133 +++++++++++++
 tb/tb_skewed_operand_buffer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/skewed_operand_buffer_if.sv
// Host-side bundle for the skewed operand buffer. It carries the element write port,
// the stream control inputs and the registered stream outputs.
interface skewed_operand_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LINES      = 4,
    parameter int DEPTH      = 4
);
    localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int ELEM_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                        write_enable;
    logic [LINE_W-1:0]           write_line;
    logic [ELEM_W-1:0]           write_elem;
    logic [DATA_WIDTH-1:0]       data_in;
    logic                        clear;
    logic                        start;
    logic                        skew_en;
    logic [LINES*DATA_WIDTH-1:0] data_out;
    logic [LINES-1:0]            out_valid;
    logic                        busy;
    logic                        done;
    logic                        wr_reject;

    modport master (
        output write_enable, write_line, write_elem, data_in, clear, start, skew_en,
        input  data_out, out_valid, busy, done, wr_reject
    );

    modport slave (
        input  write_enable, write_line, write_elem, data_in, clear, start, skew_en,
        output data_out, out_valid, busy, done, wr_reject
    );
endinterface

// File: rtl/skewed_operand_buffer.sv
// LINES x DEPTH operand store feeding a systolic array. On start, every line is streamed out
// one element per cycle, either aligned or skewed so that line i lags line 0 by i cycles.
module skewed_operand_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int LINES      = 4,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    skewed_operand_buffer_if.slave bus
);
    localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int ELEM_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(LINES + DEPTH);

    localparam logic [CNT_W-1:0]  LAST_SKEW  = CNT_W'(DEPTH + LINES - 2);
    localparam logic [CNT_W-1:0]  LAST_ALIGN = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  BEAT_ONE   = CNT_W'(1);
    localparam logic [LINE_W:0]   LINES_LIM  = (LINE_W + 1)'(LINES);
    localparam logic [ELEM_W:0]   DEPTH_LIM  = (ELEM_W + 1)'(DEPTH);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                      state, next_state;
    logic [CNT_W-1:0]            beat, next_beat;
    logic                        skew_q, load_skew;
    logic                        load;
    logic                        done_d;
    logic                        write_hit;
    int                          elem;

    logic [DATA_WIDTH-1:0]       mem [LINES][DEPTH];
    logic [LINES*DATA_WIDTH-1:0] data_q, data_d;
    logic [LINES-1:0]            valid_q, valid_d;
    logic                        done_q;
    logic                        reject_q;

    // Sequencer: decides which beat (if any) the output registers load at this edge.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        next_state = state;
        next_beat  = beat;
        load       = 1'b0;
        load_skew  = skew_q;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    next_state = STREAM;
                    next_beat  = '0;
                    load       = 1'b1;
                    load_skew  = bus.skew_en;
                end
            end
            STREAM: begin
                if (beat == (skew_q ? LAST_SKEW : LAST_ALIGN)) begin
                    next_state = IDLE;
                    next_beat  = '0;
                end else begin
                    next_beat = beat + BEAT_ONE;
                    load      = 1'b1;
                end
            end
        endcase
        done_d = load && (next_beat == (load_skew ? LAST_SKEW : LAST_ALIGN));
    end

    // Element e of line i is shown on beat e (aligned) or beat e+i (skewed).
    always_comb begin
        data_d  = '0;
        valid_d = '0;
        elem    = 0;
        for (int i = 0; i < LINES; i++) begin
            elem = load_skew ? (int'(next_beat) - i) : int'(next_beat);
            if (load && elem >= 0 && elem < DEPTH) begin
                valid_d[i]                         = 1'b1;
                data_d[i*DATA_WIDTH +: DATA_WIDTH] = mem[i][elem[ELEM_W-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat     <= '0;
            skew_q   <= 1'b0;
            data_q   <= '0;
            valid_q  <= '0;
            done_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state    <= next_state;
            beat     <= next_beat;
            skew_q   <= load_skew;
            data_q   <= data_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            reject_q <= (state == STREAM) && (bus.write_enable || bus.clear);
        end
    end

    assign write_hit = bus.write_enable
                    && ({1'b0, bus.write_line} < LINES_LIM)
                    && ({1'b0, bus.write_elem} < DEPTH_LIM);

    // The read for beat 0 happens at the same edge as a write, so it naturally sees old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this array is reset cell by cell because a zeroed store is part of the defined reset state.
            for (int i = 0; i < LINES; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    mem[i][j] <= '0;
                end
            end
        end else if (state == IDLE) begin
            if (bus.clear) begin
                for (int i = 0; i < LINES; i++) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        mem[i][j] <= '0;
                    end
                end
            end else if (write_hit) begin
                mem[bus.write_line][bus.write_elem] <= bus.data_in;
            end
        end
    end

    assign bus.data_out  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = (state == STREAM);
    assign bus.done      = done_q;
    assign bus.wr_reject = reject_q;
endmodule

// File: tb/tb_skewed_operand_buffer.sv
// Self-checking bench for skewed_operand_buffer: a cycle-level reference model checked every
// cycle, plus directed streams with literal expectations.
module tb_skewed_operand_buffer;
    localparam int DW = 8;
    localparam int L  = 4;
    localparam int D  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   done_pulses = 0;

    always #5 clk = ~clk;

    skewed_operand_buffer_if #(.DATA_WIDTH(DW), .LINES(L), .DEPTH(D)) bus ();

    skewed_operand_buffer #(.DATA_WIDTH(DW), .LINES(L), .DEPTH(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a stream is a start time plus a beat count; the output for beat t
    // is looked up from the model array as it stands just before the edge that shows it.
    logic [DW-1:0] m_mem [L][D];
    logic          m_active = 1'b0;
    logic          m_skew   = 1'b0;
    logic          was_busy = 1'b0;
    int            m_t      = 0;
    int            m_len    = 0;
    logic [L*DW-1:0] exp_data   = '0;
    logic [L-1:0]    exp_valid  = '0;
    logic            exp_busy   = 1'b0;
    logic            exp_done   = 1'b0;
    logic            exp_reject = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++)
                for (int j = 0; j < D; j++) m_mem[i][j] = '0;
            m_active = 1'b0; m_skew = 1'b0; m_t = 0; m_len = 0;
            exp_data = '0; exp_valid = '0; exp_busy = 1'b0; exp_done = 1'b0; exp_reject = 1'b0;
        end else begin
            was_busy   = m_active;
            exp_reject = was_busy && (bus.write_enable || bus.clear);
            if (m_active) begin
                m_t++;
                if (m_t == m_len) m_active = 1'b0;
            end else if (bus.start) begin
                m_active = 1'b1;
                m_t      = 0;
                m_skew   = bus.skew_en;
                m_len    = bus.skew_en ? (D + L - 1) : D;
            end
            exp_busy  = m_active;
            exp_done  = m_active && (m_t == m_len - 1);
            exp_data  = '0;
            exp_valid = '0;
            if (m_active) begin
                for (int i = 0; i < L; i++) begin
                    int e;
                    e = m_skew ? m_t - i : m_t;
                    if (e >= 0 && e < D) begin
                        exp_valid[i]           = 1'b1;
                        exp_data[i*DW +: DW]   = m_mem[i][e];
                    end
                end
            end
            if (!was_busy) begin
                if (bus.clear) begin
                    for (int i = 0; i < L; i++)
                        for (int j = 0; j < D; j++) m_mem[i][j] = '0;
                end else if (bus.write_enable && int'(bus.write_line) < L && int'(bus.write_elem) < D) begin
                    m_mem[bus.write_line][bus.write_elem] = bus.data_in;
                end
            end
        end
    end

    // Every-cycle comparison against the model, on the inactive edge.
    always @(negedge clk) begin
        check("cyc_data",   64'(bus.data_out),  64'(exp_data));
        check("cyc_valid",  64'(bus.out_valid), 64'(exp_valid));
        check("cyc_busy",   64'(bus.busy),      64'(exp_busy));
        check("cyc_done",   64'(bus.done),      64'(exp_done));
        check("cyc_reject", 64'(bus.wr_reject), 64'(exp_reject));
        if (bus.done) done_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_cell(input int l, input int e, input int d);
        bus.write_enable = 1'b1;
        bus.write_line   = 2'(l);
        bus.write_elem   = 2'(e);
        bus.data_in      = 8'(d);
        tick();
        bus.write_enable = 1'b0;
    endtask

    task automatic preload();
        for (int i = 0; i < L; i++)
            for (int j = 0; j < D; j++) write_cell(i, j, 16 * i + j);
    endtask

    task automatic begin_stream(input logic skew);
        bus.start   = 1'b1;
        bus.skew_en = skew;
        tick();
        bus.start   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 40) begin
            tick();
            n++;
        end
        check("idle_timeout", 64'(bus.busy), 64'(0));
    endtask

    initial begin
        int busy_cycles;
        int last_rise;
        int rises;
        int dp0;
        logic prev_busy;

        bus.write_enable = 1'b0; bus.write_line = '0; bus.write_elem = '0; bus.data_in = '0;
        bus.clear = 1'b0; bus.start = 1'b0; bus.skew_en = 1'b0;

        #12;
        check("rst_data",   64'(bus.data_out),  64'(0));
        check("rst_valid",  64'(bus.out_valid), 64'(0));
        check("rst_busy",   64'(bus.busy),      64'(0));
        check("rst_done",   64'(bus.done),      64'(0));
        check("rst_reject", 64'(bus.wr_reject), 64'(0));
        rst_n = 1'b1;
        tick();
        preload();

        // Skewed stream over the preloaded pattern.
        begin_stream(1'b1);
        busy_cycles = 0;
        for (int t = 0; t < 7; t++) begin
            if (bus.busy) busy_cycles++;
            case (t)
                0: begin
                    check("skew_b0_valid", 64'(bus.out_valid), 64'(4'b0001));
                    check("skew_b0_data",  64'(bus.data_out),  64'(32'h0000_0000));
                end
                1: begin
                    check("skew_b1_valid", 64'(bus.out_valid), 64'(4'b0011));
                    check("skew_b1_data",  64'(bus.data_out),  64'(32'h0000_1001));
                end
                3: begin
                    check("skew_b3_valid", 64'(bus.out_valid), 64'(4'b1111));
                    check("skew_b3_data",  64'(bus.data_out),  64'(32'h3021_1203));
                    check("model_pin_b3",  64'(exp_data),      64'(32'h3021_1203));
                end
                6: begin
                    check("skew_b6_valid", 64'(bus.out_valid), 64'(4'b1000));
                    check("skew_b6_data",  64'(bus.data_out),  64'(32'h3300_0000));
                    check("skew_b6_done",  64'(bus.done),      64'(1));
                    check("model_pin_b6",  64'(exp_done),      64'(1));
                end
                default: ;
            endcase
            tick();
        end
        check("skew_busy_len", 64'(busy_cycles),   64'(7));
        check("skew_end_data", 64'(bus.data_out),  64'(0));
        check("skew_end_valid",64'(bus.out_valid), 64'(0));
        check("skew_end_busy", 64'(bus.busy),      64'(0));

        // Aligned stream.
        begin_stream(1'b0);
        for (int t = 0; t < 4; t++) begin
            check("align_valid", 64'(bus.out_valid), 64'(4'b1111));
            if (t == 2) check("align_b2_data", 64'(bus.data_out), 64'(32'h3222_1202));
            check("align_done", 64'(bus.done), 64'(t == 3));
            tick();
        end
        check("align_end_busy", 64'(bus.busy), 64'(0));

        // Write attempted mid-stream is dropped and flagged.
        begin_stream(1'b1);
        tick();
        tick();
        write_cell(1, 2, 8'hAA);
        check("wr_busy_reject", 64'(bus.wr_reject),      64'(1));
        check("wr_busy_b3",     64'(bus.data_out[15:8]), 64'(8'h12));
        tick();
        check("wr_busy_reject_clr", 64'(bus.wr_reject), 64'(0));
        wait_idle();
        tick();
        begin_stream(1'b0);
        tick();
        tick();
        check("wr_busy_unchanged", 64'(bus.data_out[15:8]), 64'(8'h12));
        wait_idle();
        tick();

        // Write on the start edge: beat 0 reads the old value.
        bus.write_enable = 1'b1; bus.write_line = 2'd0; bus.write_elem = 2'd0; bus.data_in = 8'h5A;
        begin_stream(1'b0);
        bus.write_enable = 1'b0;
        check("rbw_old", 64'(bus.data_out[7:0]), 64'(8'h00));
        wait_idle();
        tick();
        begin_stream(1'b0);
        check("rbw_new", 64'(bus.data_out[7:0]), 64'(8'h5A));
        wait_idle();
        tick();

        // Start held high: a new aligned stream every T+1 = 5 cycles.
        bus.start = 1'b1; bus.skew_en = 1'b0;
        last_rise = -1; rises = 0; prev_busy = 1'b0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (bus.busy && !prev_busy) begin
                if (last_rise >= 0) check("hold_period", 64'(c - last_rise), 64'(5));
                last_rise = c;
                rises++;
            end
            prev_busy = bus.busy;
        end
        bus.start = 1'b0;
        check("hold_rises", 64'(rises), 64'(4));
        wait_idle();
        tick();

        // Reset in the middle of a skewed stream.
        dp0 = done_pulses;
        begin_stream(1'b1);
        repeat (4) tick();
        check("mid_busy", 64'(bus.busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("mid_rst_data",  64'(bus.data_out),  64'(0));
        check("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        check("mid_rst_busy",  64'(bus.busy),      64'(0));
        #2;
        rst_n = 1'b1;
        repeat (4) tick();
        check("mid_rst_no_done", 64'(done_pulses), 64'(dp0));
        begin_stream(1'b0);
        for (int t = 0; t < 4; t++) begin
            check("post_rst_data",  64'(bus.data_out),  64'(0));
            check("post_rst_valid", 64'(bus.out_valid), 64'(4'b1111));
            tick();
        end
        tick();

        // Clear in IDLE, then a skewed stream of zeros; a clear during the stream is rejected.
        preload();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        begin_stream(1'b1);
        for (int t = 0; t < 7; t++) begin
            bus.clear = 1'b0;
            check("clr_data", 64'(bus.data_out), 64'(0));
            if (t == 3) begin
                check("clr_b3_valid",  64'(bus.out_valid), 64'(4'b1111));
                check("clr_busy_rej",  64'(bus.wr_reject), 64'(1));
            end
            if (t == 2) bus.clear = 1'b1;
            tick();
        end
        check("clr_end_busy", 64'(bus.busy), 64'(0));
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
